// File: rtl/pipelined_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_subtractor_pkg
// Shared FIR arithmetic package: default datapath geometry and the per-chunk
// subtract primitive used by the pipelined subtractor (and adder family).
// No ports.
// -----------------------------------------------------------------------------
package pipelined_subtractor_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;
    // Widest chunk the shared primitive handles; callers zero-extend into it.
    localparam int MAX_CHUNK  = 32;

    typedef struct packed {
        logic                 brw;
        logic [MAX_CHUNK-1:0] d;
    } chunk_res_t;

    // {brw, d} = {0,a} - {0,b} - bin. With zero-extended narrower operands the
    // top bit still equals the chunk borrow, because a negative result sets
    // every bit from the chunk MSB+1 upwards.
    function automatic chunk_res_t sub_chunk(input logic [MAX_CHUNK-1:0] a,
                                             input logic [MAX_CHUNK-1:0] b,
                                             input logic                 bin);
        logic [MAX_CHUNK:0] t;
        chunk_res_t         r;
        t     = {1'b0, a} - {1'b0, b} - {{MAX_CHUNK{1'b0}}, bin};
        r.brw = t[MAX_CHUNK];
        r.d   = t[MAX_CHUNK-1:0];
        return r;
    endfunction

endpackage

// File: rtl/pipelined_subtractor_if.sv
// -----------------------------------------------------------------------------
// pipelined_subtractor_if
// Operand/result bundle for the pipelined subtractor.
//   ce, in_valid, a, b, bin      : producer -> subtractor
//   out_valid, diff, bout, ovf   : subtractor -> consumer
// master = producer/consumer side, slave = subtractor side.
// -----------------------------------------------------------------------------
interface pipelined_subtractor_if
    import pipelined_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             ce;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output ce, in_valid, a, b, bin,
        input  out_valid, diff, bout, ovf
    );

    modport slave (
        input  ce, in_valid, a, b, bin,
        output out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/pipelined_subtractor_stage.sv
// -----------------------------------------------------------------------------
// pipe_sub_stage
// One CHUNK-wide slice of the ripple-borrow pipeline: subtracts the chunk
// operands and incoming borrow, registers difference and borrow out.
// Ports:
//   clk, reset       : clock, async active-high reset
//   i_ce             : clock enable (0 holds registers)
//   i_a, i_b, i_brw  : chunk operands and borrow in
//   o_diff, o_brw    : registered chunk difference and borrow out
// -----------------------------------------------------------------------------
module pipe_sub_stage
    import pipelined_subtractor_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_ce,
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_brw,
    output logic [CHUNK-1:0] o_diff,
    output logic             o_brw
);
    chunk_res_t       w_res;
    logic [CHUNK-1:0] r_diff;
    logic             r_brw;

    if (CHUNK > MAX_CHUNK) begin : g_bad_chunk
        $error("pipe_sub_stage: CHUNK exceeds MAX_CHUNK");
    end

    assign w_res = sub_chunk(MAX_CHUNK'(i_a), MAX_CHUNK'(i_b), i_brw);

    // Upper bits of the shared primitive only replicate the borrow here.
    if (CHUNK < MAX_CHUNK) begin : g_pad
        logic w_unused_pad;
        assign w_unused_pad = ^w_res.d[MAX_CHUNK-1:CHUNK];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_diff <= '0;
            r_brw  <= 1'b0;
        end else if (i_ce) begin
            r_diff <= w_res.d[CHUNK-1:0];
            r_brw  <= w_res.brw;
        end
    end

    assign o_diff = r_diff;
    assign o_brw  = r_brw;
endmodule

// File: rtl/pipelined_subtractor.sv
// -----------------------------------------------------------------------------
// pipelined_subtractor
// Fully pipelined ripple-borrow subtractor: diff = a - b - bin mod 2^WIDTH,
// one CHUNK resolved per stage, latency STAGES enabled cycles, one result per
// enabled cycle.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset, clears every pipeline register
//   bus   : slave side of pipelined_subtractor_if (ce, in_valid, a, b, bin ->
//           out_valid, diff, bout, ovf)
// -----------------------------------------------------------------------------
module pipelined_subtractor
    import pipelined_subtractor_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic                   clk,
    input  logic                   reset,
    pipelined_subtractor_if.slave  bus
);
    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_geom
        $error("pipelined_subtractor: WIDTH must be a multiple of STAGES >= 1");
    end

    // Operands as seen by stage k, stage outputs, and deskewed result chunks.
    logic [STAGES-1:0][CHUNK-1:0] w_a_stg;
    logic [STAGES-1:0][CHUNK-1:0] w_b_stg;
    logic [STAGES-1:0][CHUNK-1:0] w_d_stg;
    logic [STAGES-1:0][CHUNK-1:0] w_d_out;
    logic [STAGES-1:0]            w_brw;
    logic [STAGES:1]              r_vld;
    logic                         r_a_msb;
    logic                         r_b_msb;

    for (genvar k = 0; k < STAGES; k++) begin : g_lane
        localparam int DSK = STAGES - 1 - k;
        logic [CHUNK-1:0] w_a_in;
        logic [CHUNK-1:0] w_b_in;
        logic             w_brw_in;

        assign w_a_in = bus.a[k*CHUNK +: CHUNK];
        assign w_b_in = bus.b[k*CHUNK +: CHUNK];

        // Chunk k is delayed k cycles so it meets the borrow from chunk k-1.
        if (k == 0) begin : g_noskew
            assign w_a_stg[k] = w_a_in;
            assign w_b_stg[k] = w_b_in;
            assign w_brw_in   = bus.bin;
        end else begin : g_skew
            logic [k-1:0][CHUNK-1:0] r_a_sk;
            logic [k-1:0][CHUNK-1:0] r_b_sk;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_a_sk <= '0;
                    r_b_sk <= '0;
                end else if (bus.ce) begin
                    r_a_sk[0] <= w_a_in;
                    r_b_sk[0] <= w_b_in;
                    for (int j = 1; j < k; j++) begin
                        r_a_sk[j] <= r_a_sk[j-1];
                        r_b_sk[j] <= r_b_sk[j-1];
                    end
                end
            end
            assign w_a_stg[k] = r_a_sk[k-1];
            assign w_b_stg[k] = r_b_sk[k-1];
            assign w_brw_in   = w_brw[k-1];
        end

        pipe_sub_stage #(.CHUNK(CHUNK)) u_stage (
            .clk    (clk),
            .reset  (reset),
            .i_ce   (bus.ce),
            .i_a    (w_a_stg[k]),
            .i_b    (w_b_stg[k]),
            .i_brw  (w_brw_in),
            .o_diff (w_d_stg[k]),
            .o_brw  (w_brw[k])
        );

        // Early chunks wait for the top chunk to finish.
        if (DSK == 0) begin : g_nodeskew
            assign w_d_out[k] = w_d_stg[k];
        end else begin : g_deskew
            logic [DSK-1:0][CHUNK-1:0] r_d_dsk;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_d_dsk <= '0;
                end else if (bus.ce) begin
                    r_d_dsk[0] <= w_d_stg[k];
                    for (int j = 1; j < DSK; j++) begin
                        r_d_dsk[j] <= r_d_dsk[j-1];
                    end
                end
            end
            assign w_d_out[k] = r_d_dsk[DSK-1];
        end
    end

    // Valid shift register and the operand sign bits that travel with the
    // final stage so overflow is judged against the registered top chunk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (bus.ce) begin
            r_vld[1] <= bus.in_valid;
            for (int j = 2; j <= STAGES; j++) begin
                r_vld[j] <= r_vld[j-1];
            end
            r_a_msb <= w_a_stg[STAGES-1][CHUNK-1];
            r_b_msb <= w_b_stg[STAGES-1][CHUNK-1];
        end
    end

    assign bus.out_valid = r_vld[STAGES];
    assign bus.diff      = w_d_out;
    assign bus.bout      = w_brw[STAGES-1];
    assign bus.ovf       = (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d_stg[STAGES-1][CHUNK-1]);
endmodule

// File: tb/tb_pipelined_subtractor.sv
// -----------------------------------------------------------------------------
// tb_pipelined_subtractor
// Directed bench for pipelined_subtractor (WIDTH=16, STAGES=4): reset state,
// single-op latency, back-to-back stream, ce stalls, bubbles, async reset with
// results in flight. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_pipelined_subtractor;
    localparam int W = 16;
    localparam int S = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t V [12];

    always #5 clk = ~clk;

    pipelined_subtractor_if #(.WIDTH(W)) bus ();

    pipelined_subtractor #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input int idx);
        chk({tag, "_valid"}, W'(bus.out_valid), W'(1'b1));
        chk({tag, "_diff"},  bus.diff,          V[idx].d);
        chk({tag, "_bout"},  W'(bus.bout),      W'(V[idx].bo));
        chk({tag, "_ovf"},   W'(bus.ovf),       W'(V[idx].ov));
    endtask

    task automatic drive(input logic v, input int idx);
        bus.in_valid = v;
        bus.a        = V[idx].a;
        bus.b        = V[idx].b;
        bus.bin      = V[idx].bin;
    endtask

    initial begin
        //              a         b         bin   diff      bout  ovf
        V[0]  = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};
        V[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        V[2]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        V[3]  = '{16'h7FFF, 16'h8000, 1'b1, 16'hFFFE, 1'b1, 1'b1};
        V[4]  = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        V[5]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0};
        V[6]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        V[7]  = '{16'h5678, 16'h1234, 1'b0, 16'h4444, 1'b0, 1'b0};
        V[8]  = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b1};
        V[9]  = '{16'h0100, 16'h00FF, 1'b0, 16'h0001, 1'b0, 1'b0};
        V[10] = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0};
        V[11] = '{16'h0010, 16'h0011, 1'b0, 16'hFFFF, 1'b1, 1'b0};

        // Reset state
        reset = 1'b1;
        bus.ce = 1'b0;
        drive(1'b0, 0);
        #1;
        chk("rst_valid", W'(bus.out_valid), '0);
        chk("rst_diff",  bus.diff,          '0);
        chk("rst_bout",  W'(bus.bout),      '0);
        chk("rst_ovf",   W'(bus.ovf),       '0);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        bus.ce = 1'b1;

        // Single op: borrow ripples across three chunk boundaries, latency 4
        drive(1'b1, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("lat3_valid", W'(bus.out_valid), '0);
        @(negedge clk);
        chk_res("lat4", 0);
        @(negedge clk);
        chk("lat5_valid", W'(bus.out_valid), '0);
        repeat (4) @(negedge clk);

        // Back-to-back stream of every vector
        for (int c = 0; c < 15; c++) begin
            if (c < 12) drive(1'b1, c);
            else        bus.in_valid = 1'b0;
            @(negedge clk);
            if (c >= 3) chk_res($sformatf("strm%0d", c - 3), c - 3);
        end
        repeat (4) @(negedge clk);

        // ce stalls: one op, inputs during ce=0 must be ignored
        drive(1'b1, 7);
        @(negedge clk);                         // enabled 1
        bus.in_valid = 1'b0;
        @(negedge clk);                         // enabled 2
        bus.ce = 1'b0;
        drive(1'b1, 5);
        repeat (3) begin
            @(negedge clk);
            chk("stall_pre_valid", W'(bus.out_valid), '0);
        end
        bus.ce = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);                         // enabled 3
        chk("stall_e3_valid", W'(bus.out_valid), '0);
        @(negedge clk);                         // enabled 4
        chk_res("stall_out", 7);
        bus.ce = 1'b0;
        drive(1'b1, 1);
        repeat (2) begin
            @(negedge clk);
            chk_res("stall_hold", 7);
        end
        bus.ce = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("stall_after_valid", W'(bus.out_valid), '0);
        repeat (4) @(negedge clk);

        // Bubbles: in_valid 1,0,1,1,0
        begin
            logic pv [5];
            int   pi [5];
            pv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
            pi = '{8, 0, 9, 10, 0};
            for (int c = 0; c < 8; c++) begin
                if (c < 5) drive(pv[c], pi[c]);
                else       bus.in_valid = 1'b0;
                @(negedge clk);
                if (c >= 3) begin
                    if (pv[c-3]) chk_res($sformatf("bub%0d", c - 3), pi[c-3]);
                    else         chk($sformatf("bub%0d_valid", c - 3), W'(bus.out_valid), '0);
                end
            end
        end
        repeat (4) @(negedge clk);

        // Async reset with three results in flight
        for (int c = 1; c <= 5; c++) begin
            drive(1'b1, c);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk_res("prerst", 2);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", W'(bus.out_valid), '0);
        chk("arst_diff",  bus.diff,          '0);
        chk("arst_bout",  W'(bus.bout),      '0);
        chk("arst_ovf",   W'(bus.ovf),       '0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("postrst%0d_valid", c), W'(bus.out_valid), '0);
        end

        // Pipeline works again after reset
        drive(1'b1, 11);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_res("postrst_op", 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipelined_subtractor.md
Name: pipelined_subtractor

Overview:
- Parameterised, fully pipelined ripple-borrow subtractor computing diff = a - b - bin over WIDTH bits.
- The operand is split into STAGES equal chunks, with one chunk resolved per stage.
  - Upper-chunk operands are skewed forward through registers.
  - Lower-chunk results are deskewed to the output.
- Sits beside the pipelined adder in the FIR datapath (difference taps, symmetric-filter pre-subtract, error terms).
- Sustains one result per clock when enabled.

Parameters:
- WIDTH, 16, operand and result width in bits.
- STAGES, 4, pipeline depth = number of chunks. WIDTH mod STAGES must be 0, else elaboration error. STAGES >= 1.
- CHUNK, WIDTH/STAGES, derived local constant (not overridable). Bits resolved per stage.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable. 0 freezes the entire pipeline.
- in_valid  in  1  qualifies a, b, bin this cycle.
- a  in  WIDTH  minuend, unsigned or two's complement.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow in (1 subtracts an extra 1).
- out_valid  out  1  diff/bout/ovf hold a valid result.
- diff  out  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  out  1  unsigned borrow out (1 iff a < b + bin as unsigned).
- ovf  out  1  two's-complement overflow of the signed result.

Behaviour:
- Reset (async assert, sync-to-clk release): every pipeline register clears to 0.
  - This covers skew registers, deskew registers, borrow registers and valid bits.
  - out_valid=0, diff=0, bout=0, ovf=0.
  - A reset mid-stream discards all in-flight results. No stale out_valid after release.
- Stage k (k=0..STAGES-1) handles bits [k*CHUNK +: CHUNK]:
  - {brw_k, d_k} = {1'b0, a_k} - {1'b0, b_k} - borrow_k, in CHUNK+1 bits.
  - brw_k = MSB of that result.
  - borrow_0 = bin (sampled at the input).
  - borrow_k = registered brw_(k-1).
- Chunk k of a and b passes through k skew registers before stage k.
- Result chunk k passes through STAGES-1-k deskew registers. Every chunk therefore emerges aligned.
- bout = brw_(STAGES-1), registered at the final stage.
- ovf = (a_msb ^ b_msb) & (a_msb ^ diff_msb), using the skewed a/b MSBs in the final stage.
- Latency: exactly STAGES enabled cycles from an in_valid=1 sample to the matching out_valid=1.
  - in_valid is carried in a STAGES-deep shift register alongside the data.
- Throughput: one operation per enabled cycle. No back-pressure beyond ce.
- ce=0: all registers (data, borrow, valid) hold. Outputs remain stable and out_valid keeps its value. Inputs are ignored that cycle.
- in_valid=0 with ce=1: a bubble propagates. Data registers may still load don't-care operands. out_valid=0 for that slot, and diff/bout/ovf are unspecified when out_valid=0 after reset.
- Wrap-around: 0 - 1 gives diff=all-ones, bout=1.
- STAGES=1 degenerates to a single registered full-width subtract with latency 1.
- Borrow must ripple correctly across all chunk boundaries (e.g. 0x1000 - 1).

Decomposition:
- Shared package fir_arith_pkg:
  - Default WIDTH/STAGES constants.
  - A function computing {borrow, diff} for one chunk, reused by the adder family.
- One natural sub-module: pipe_sub_stage (one CHUNK slice).
  - Registers the chunk difference and borrow out, gated by ce, reset by reset.
  - The top instantiates it STAGES times with generate loops for the skew and deskew register chains.

Test Plan:
- WIDTH=16, STAGES=4: a=0x1000, b=0x0001, bin=0 -> after exactly 4 cycles diff=0x0FFF, bout=0, ovf=0 (borrow crosses 3 chunk boundaries).
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1. a=0x7FFF, b=0x8000, bin=1 -> diff=0xFFFE, ovf=1.
- Back-to-back stream: 1000 random (a, b, bin) with in_valid=1 every cycle -> each result matches a reference model exactly 4 cycles later. out_valid continuous.
- ce toggled randomly mid-stream -> output sequence identical to the ce=1 run, with stalls only. Outputs stable while ce=0.
- Bubbles: in_valid pattern 1,0,1,1,0 -> out_valid shows the same pattern delayed 4 cycles.
- Reset asserted asynchronously while 3 results are in flight -> out_valid/diff/bout/ovf go to 0 immediately. No valid output appears for the next 4 cycles unless new in_valid arrives.
